key_select_n: RTL and testbench

KEY_SELECT_N -- requirements
Module: key_select_n

---
 rtl/key_select_n.sv | 160 ++++++++++++++++
 tb/tb_key_select_n.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_select_n.sv
// Debounced N-key selector: synchronizes and debounces active-low keys, detects press/long-press, keeps a one-hot selection.
// Latency: key_press 2+DEB_CYC cycles after a stable low key; selection outputs update one cycle after the key_press pulse.
// Backpressure: none; all outputs are free-running registered pulses and levels.
module key_select_n #(
  parameter int N_KEYS   = 4,
  parameter int DEB_CYC  = 1000000,
  parameter int LONG_CYC = 50000000,
  parameter int MODE     = 0,
  localparam int IDXW    = (N_KEYS == 1) ? 1 : $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_choose,
  output logic [IDXW-1:0]   key_idx,
  output logic              key_valid,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_long
);

  // Debounce counter only needs to reach DEB_CYC-1; long counter saturates at LONG_CYC-1.
  localparam int DW = $clog2(DEB_CYC);
  localparam int LW = $clog2(LONG_CYC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } st_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          deb;
    logic [DW-1:0] deb_cnt;
    st_t           state;
    st_t           state_nxt;
    logic [LW-1:0] long_cnt;
    logic          long_hit;
    logic          press_set;
    logic          long_set;
    logic          press_q;
    logic          long_q;

    assign long_hit = (long_cnt == LW'(LONG_CYC - 1));

    // Two-flop synchronizer; idles high so reset looks like a released key.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_in[i];
        sync2 <= sync1;
      end
    end

    // Debounce: any cycle that agrees with the current level restarts the window.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        deb     <= 1'b1;
        deb_cnt <= '0;
      end else if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end

    // Press FSM state register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
    end

    // Press FSM next state: release always wins over the long-press threshold.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (!deb) state_nxt = PRESSED;
        PRESSED: begin
          if (deb)           state_nxt = IDLE;
          else if (long_hit) state_nxt = LONG;
        end
        LONG:    if (deb) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Press FSM outputs: transition strobes, registered below into one-cycle pulses.
    always_comb begin
      press_set = (state == IDLE) && !deb;
      long_set  = (state == PRESSED) && !deb && long_hit;
    end

    // Hold-time counter: cleared while released, saturates so LONG never re-fires.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              long_cnt <= '0;
      else if (state == IDLE)                long_cnt <= '0;
      else if (state == PRESSED && !long_hit) long_cnt <= long_cnt + 1'b1;
    end

    // Registered press/long pulses.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        press_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        press_q <= press_set;
        long_q  <= long_set;
      end
    end

    assign key_press[i] = press_q;
    assign key_long[i]  = long_q;
  end

  logic [N_KEYS-1:0] win_oh;
  logic [IDXW-1:0]   win_idx;

  // Lowest-index press wins among simultaneous presses.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int j = N_KEYS - 1; j >= 0; j--) begin
      if (key_press[j]) begin
        win_oh     = '0;
        win_oh[j]  = 1'b1;
        win_idx    = IDXW'(j);
      end
    end
  end

  // Selection register: a press outranks a same-cycle long-press clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_choose <= '0;
      key_idx    <= '0;
      key_valid  <= 1'b0;
    end else if (|key_press) begin
      if (MODE == 1 && win_oh == key_choose) begin
        key_choose <= '0;
        key_idx    <= '0;
        key_valid  <= 1'b0;
      end else begin
        key_choose <= win_oh;
        key_idx    <= win_idx;
        key_valid  <= 1'b1;
      end
    end else if (|key_long) begin
      key_choose <= '0;
      key_idx    <= '0;
      key_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_select_n.sv
// Bench for key_select_n: two instances (latch and toggle mode) share stimulus.
// A history-based reference model is checked every cycle; directed scenarios pin literal values.
module tb_key_select_n;
  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_in = '1;

  logic [NK-1:0] choose0, choose1, press0, press1, long0, long1;
  logic [1:0]    idx0, idx1;
  logic          valid0, valid1;

  int checks = 0;
  int errors = 0;

  key_select_n #(.N_KEYS(NK), .DEB_CYC(DEB), .LONG_CYC(LONG), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_choose(choose0), .key_idx(idx0),
    .key_valid(valid0), .key_press(press0), .key_long(long0));

  key_select_n #(.N_KEYS(NK), .DEB_CYC(DEB), .LONG_CYC(LONG), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_choose(choose1), .key_idx(idx1),
    .key_valid(valid1), .key_press(press1), .key_long(long1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounced level flips once the last DEB raw samples that have reached the
  // synchronizer output all disagree with it. Selection is kept as an index (-1 = none).
  logic [NK-1:0] hq[$];
  logic [NK-1:0] mdeb, mpress, mlong;
  int            mst[NK];   // 0 released, 1 held, 2 held past long threshold
  int            age[NK];
  int            msel0, msel1;

  task automatic reset_model();
    mdeb = '1; mpress = '0; mlong = '0; msel0 = -1; msel1 = -1;
    for (int i = 0; i < NK; i++) begin mst[i] = 0; age[i] = 0; end
    hq.delete();
    repeat (DEB + 1) hq.push_back('1);
  endtask

  task automatic model_step();
    logic [NK-1:0] np, nl, ndeb;
    int w;
    if (!rst) begin reset_model(); return; end
    np = '0; nl = '0;
    for (int i = 0; i < NK; i++) begin
      if (mst[i] == 0) begin
        if (!mdeb[i]) begin mst[i] = 1; age[i] = 0; np[i] = 1'b1; end
      end else if (mdeb[i]) begin
        mst[i] = 0;
      end else if (mst[i] == 1) begin
        age[i]++;
        if (age[i] == LONG) begin nl[i] = 1'b1; mst[i] = 2; end
      end
    end
    w = -1;
    for (int j = NK - 1; j >= 0; j--) if (mpress[j]) w = j;
    if (w >= 0) begin
      msel0 = w;
      msel1 = (msel1 == w) ? -1 : w;
    end else if (mlong != 0) begin
      msel0 = -1; msel1 = -1;
    end
    ndeb = mdeb;
    for (int i = 0; i < NK; i++) begin
      bit all_diff = 1'b1;
      for (int k = 1; k <= DEB; k++) if (hq[k][i] == mdeb[i]) all_diff = 1'b0;
      if (all_diff) ndeb[i] = ~mdeb[i];
    end
    mdeb = ndeb;
    hq.push_front(key_in);
    void'(hq.pop_back());
    mpress = np; mlong = nl;
  endtask

  function automatic logic [NK-1:0] oh(input int s);
    logic [NK-1:0] r;
    r = '0;
    if (s >= 0) r[s] = 1'b1;
    return r;
  endfunction

  // Every-cycle comparison against the model, sampled 1 time unit after the edge.
  initial begin
    reset_model();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("press0", press0, mpress);
      chk("press1", press1, mpress);
      chk("long0", long0, mlong);
      chk("long1", long1, mlong);
      chk("choose0", choose0, oh(msel0));
      chk("idx0", idx0, (msel0 < 0) ? 0 : msel0);
      chk("valid0", valid0, msel0 >= 0);
      chk("choose1", choose1, oh(msel1));
      chk("idx1", idx1, (msel1 < 0) ? 0 : msel1);
      chk("valid1", valid1, msel1 >= 0);
    end
  end

  // ---------------- stimulus ----------------
  int nb_press1;
  int hold[NK];

  initial begin
    rst = 1'b0;
    key_in = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_choose", choose0, 4'b0000);
    chk("rst_valid", valid0, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);

    // Key 2 held low: press at cycle 6, selection at cycle 7, long at cycle 26.
    key_in[2] = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("k2_press", press0, 4'b0100);
    @(posedge clk);
    #1;
    chk("k2_choose", choose0, 4'b0100);
    chk("k2_idx", idx0, 2);
    chk("k2_valid", valid0, 1'b1);
    repeat (19) @(posedge clk);
    #1 chk("k2_long", long0, 4'b0100);
    @(posedge clk);
    #1;
    chk("k2_long_clr0", choose0, 4'b0000);
    chk("k2_long_clr1", choose1, 4'b0000);
    repeat (10) @(negedge clk);
    key_in[2] = 1'b1;
    repeat (15) @(negedge clk);

    // Keys 3 and 1 on the same edge: both pulse, key 1 wins.
    key_in[3] = 1'b0; key_in[1] = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("dual_press", press0, 4'b1010);
    @(posedge clk);
    #1;
    chk("dual_choose", choose0, 4'b0010);
    chk("dual_idx", idx0, 1);
    @(negedge clk);
    key_in[3] = 1'b1; key_in[1] = 1'b1;
    repeat (15) @(negedge clk);

    // Toggle mode: key 0 pressed twice selects then deselects.
    key_in[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("tog_sel", choose1, 4'b0001);
    @(negedge clk) key_in[0] = 1'b1;
    repeat (15) @(negedge clk);
    key_in[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("tog_desel", choose1, 4'b0000);
    chk("tog_valid", valid1, 1'b0);
    chk("latch_keep", choose0, 4'b0001);
    @(negedge clk) key_in[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Key 1 bouncing every 2 cycles never settles long enough.
    nb_press1 = 0;
    for (int k = 0; k < 20; k++) begin
      key_in[1] = ((k / 2) % 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      nb_press1 += press0[1];
    end
    key_in[1] = 1'b1;
    repeat (10) begin @(negedge clk); nb_press1 += press0[1]; end
    chk("bounce_nopress", nb_press1, 0);
    chk("bounce_choose", choose0, 4'b0001);

    // Reset mid-press discards progress; fresh press 6 cycles after release.
    key_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("inrst_choose", choose0, 4'b0000);
      chk("inrst_press", press0, 4'b0000);
      chk("inrst_long", long0, 4'b0000);
      chk("inrst_idx", idx0, 0);
      chk("inrst_valid", valid0, 1'b0);
    end
    @(negedge clk) rst = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("rst_repress", press0, 4'b0001);
    @(negedge clk) key_in[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Randomized key activity with mixed short (bouncy) and long holds.
    for (int i = 0; i < NK; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 2000) rst = 1'b0;
      if (c == 2002) rst = 1'b1;
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          key_in[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end else begin
          hold[i]--;
        end
      end
    end
    key_in = '1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
